// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit seven-segment scan controller:
// FSM state encoding, digit index width, all-off drive constants,
// the 0..9 active-low segment table and the displayed value pair.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int DIG_W = 2;
  // Scan starts on the leftmost digit (tens of a).
  localparam logic [DIG_W-1:0] DIG_FIRST = DIG_W'(3);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Segments {g,f,e,d,c,b,a}, active-low, index = decimal digit.
  localparam logic [0:9][6:0] SEG_TABLE = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       blank_lz;
  } disp_val_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load/display bundle of the scan controller.
//   load, val_a, val_b, blank_lz : value pair request (master -> slave)
//   ready                        : load accepted this cycle (slave -> master)
//   an, seg                      : active-low anode and segment drives
//   frame_done                   : one-cycle pulse at the end of each scan
interface seg_scan_ctrl_if;
  logic       load;
  logic [3:0] val_a;
  logic [3:0] val_b;
  logic       blank_lz;
  logic       ready;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;

  modport master (
    output load, val_a, val_b, blank_lz,
    input  ready, an, seg, frame_done
  );

  modport slave (
    input  load, val_a, val_b, blank_lz,
    output ready, an, seg, frame_done
  );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment encoder.
//   digit : 4-bit decimal digit (10..15 produce all segments off)
//   seg   : {g,f,e,d,c,b,a}, active-low
module bcd_to_seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_OFF;
    if (digit <= 4'd9) seg = SEG_TABLE[digit];
  end
endmodule

// File: rtl/dec_digit.sv
// Decimal digit decoder for a 0..15 value.
//   v : 4-bit value
//   z : tens digit (1 when v > 9)
//   m : ones digit (v, or v - 10 when v > 9)
module dec_digit (
  input  logic [3:0] v,
  output logic       z,
  output logic [3:0] m
);
  assign z = (v > 4'd9);
  assign m = z ? (v - 4'd10) : v;
endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller showing two 0..15
// operands as two decimal digits each. Every digit slot is one blanking
// cycle followed by PRESCALE-1 lit cycles; new values queue in a pending
// register and take effect at the next frame boundary.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of seg_scan_ctrl_if (load/ready, an, seg, frame_done)
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam logic [15:0] SLOT_LAST = 16'(PRESCALE - 1);

  state_t           state_q, state_d;
  logic [DIG_W-1:0] digit_q, digit_d;
  logic [15:0]      slot_q, slot_d;
  logic             ready_q;
  logic             pend_valid_q;
  disp_val_t        pend_q, disp_q, in_val;

  logic       accept;
  logic       tens_a, tens_b;
  logic [3:0] ones_a, ones_b;
  logic [3:0] cur_digit;
  logic       cur_is_tens;
  logic [6:0] digit_seg, shown_seg;
  logic [3:0] an_c;
  logic [6:0] seg_c;
  logic       frame_done_c;

  assign in_val = {bus.val_a, bus.val_b, bus.blank_lz};
  assign accept = bus.load && ready_q;

  dec_digit u_dec_a (.v(disp_q.a), .z(tens_a), .m(ones_a));
  dec_digit u_dec_b (.v(disp_q.b), .z(tens_b), .m(ones_b));

  always_comb begin
    cur_digit   = ones_b;
    cur_is_tens = 1'b0;
    case (digit_q)
      2'd3: begin cur_digit = {3'b000, tens_a}; cur_is_tens = 1'b1; end
      2'd2: cur_digit = ones_a;
      2'd1: begin cur_digit = {3'b000, tens_b}; cur_is_tens = 1'b1; end
      default: cur_digit = ones_b;
    endcase
  end

  bcd_to_seg u_seg (.digit(cur_digit), .seg(digit_seg));

  // Leading-zero blanking applies to tens digits only.
  assign shown_seg = (cur_is_tens && cur_digit == 4'd0 && disp_q.blank_lz)
                     ? SEG_OFF : digit_seg;

  // NOTE: every signal written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    slot_d       = slot_q;
    an_c         = AN_OFF;
    seg_c        = SEG_OFF;
    frame_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BLANK;
          digit_d = DIG_FIRST;
          slot_d  = '0;
        end
      end
      BLANK: begin
        // Anodes stay off while the segments settle on the new digit.
        seg_c   = shown_seg;
        state_d = SHOW;
        slot_d  = slot_q + 16'd1;
      end
      SHOW: begin
        an_c  = AN_OFF & ~(4'b0001 << digit_q);
        seg_c = shown_seg;
        if (slot_q == SLOT_LAST) begin
          state_d      = BLANK;
          slot_d       = '0;
          digit_d      = (digit_q == '0) ? DIG_FIRST : digit_q - DIG_W'(1);
          frame_done_c = (digit_q == '0);
        end else begin
          slot_d = slot_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      digit_q      <= DIG_FIRST;
      slot_q       <= '0;
      ready_q      <= 1'b1;
      pend_valid_q <= 1'b0;
      // NOTE: pending and display are small registers, not a memory array,
      // so they are reset; a reset mid-frame drops any queued value.
      pend_q       <= '0;
      disp_q       <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      slot_q  <= slot_d;
      if (accept) begin
        pend_q       <= in_val;
        ready_q      <= 1'b0;
        // From IDLE the value goes straight to the display, nothing queues.
        pend_valid_q <= (state_q != IDLE);
        if (state_q == IDLE) disp_q <= in_val;
      end else if (frame_done_c && pend_valid_q) begin
        disp_q       <= pend_q;
        pend_valid_q <= 1'b0;
        ready_q      <= 1'b1;
      end else if (!ready_q && !pend_valid_q) begin
        ready_q <= 1'b1;
      end
    end
  end

  assign bus.ready      = ready_q;
  assign bus.an         = an_c;
  assign bus.seg        = seg_c;
  assign bus.frame_done = frame_done_c;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 4, clock cycles per digit slot; legal range 2..65535.
REQ-002 clk  input  1  single system clock, all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 load  input  1  request to display a new value pair; qualified by ready.
REQ-005 val_a  input  4  left operand, 0..15, shown as two decimal digits on an[3:2].
REQ-006 val_b  input  4  right operand, 0..15, shown as two decimal digits on an[1:0].
REQ-007 blank_lz  input  1  1 = blank a tens digit of 0.
REQ-008 ready  output  1  1 = load is accepted this cycle.
REQ-009 an  output  4  anode enables, active-low, an[3] leftmost.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 frame_done  output  1  one-cycle pulse at the end of each full 4-digit scan.

Function
REQ-012 Each operand SHALL be split by decimal digit decode: tens = (v > 9), ones = v when v <= 9, else v - 10 (low 4 bits).
REQ-013 The FSM SHALL have states IDLE, BLANK, SHOW.
- IDLE: entered after reset; an = 4'b1111.
- BLANK: lasts exactly 1 cycle; an = 4'b1111; seg is loaded for the current digit.
- SHOW: lasts PRESCALE-1 cycles; exactly one an bit is low.
REQ-014 Scan order SHALL be digit 3, 2, 1, 0, then wrap to 3 (3 = tens of a, 2 = ones of a, 1 = tens of b, 0 = ones of b); one digit slot SHALL be PRESCALE cycles and one frame 4*PRESCALE cycles.
REQ-015 Transitions:
- IDLE -> BLANK(digit 3) on the cycle after the first accepted load.
- BLANK -> SHOW after 1 cycle.
- SHOW -> BLANK(next digit) after PRESCALE-1 cycles.
- The state SHALL never return to IDLE except through reset.
REQ-016 A load SHALL be accepted when load && ready at a rising edge; the accepted val_a, val_b and blank_lz SHALL be captured into a pending register and ready SHALL drop to 0 on the next cycle.
REQ-017 While ready = 0, load SHALL be ignored and the pending value SHALL NOT change.
REQ-018 In IDLE, the pending value SHALL transfer to the display register in the same cycle it is accepted.
REQ-019 Otherwise, the pending value SHALL transfer on the last SHOW cycle of digit 0, so the change takes effect at the start of the next frame; ready SHALL return to 1 on the following cycle.
REQ-020 A load arriving in the same cycle as a transfer SHALL NOT be accepted, because ready is still 0.
REQ-021 frame_done SHALL be 1 for exactly the last SHOW cycle of digit 0.
REQ-022 A tens digit SHALL show seg = 7'b1111111 when it is 0 and the displayed blank_lz = 1; ones digits SHALL never be blanked.
REQ-023 The segment encoding for 0..9 SHALL be 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex, active-low).
REQ-024 The slot counter SHALL count 0..PRESCALE-1 and wrap; no other counter SHALL overflow.

Reset
REQ-025 When rst_n = 0 at a rising edge, the next state SHALL be:
- state = IDLE, an = 4'b1111, seg = 7'b1111111;
- ready = 1, frame_done = 0;
- digit index = 3, slot counter = 0;
- pending and display registers = 0.
REQ-026 Reset asserted mid-frame or while a load is pending SHALL discard the pending value; no output glitch other than the transition to the reset values is allowed.

Structure
REQ-027 A shared package SHALL hold: the state encoding (IDLE, BLANK, SHOW), the 10-entry segment table, the all-off constants AN_OFF and SEG_OFF, and the digit index width.
REQ-028 The existing decimal digit decoder (ports v, z, m) SHALL be instantiated twice, once for val_a and once for val_b.
REQ-029 A single new sub-module, bcd_to_seg (4-bit digit in, 7-bit active-low segments out, combinational), SHALL be used.

Verification (PRESCALE = 4)
REQ-030 Reset, then load val_a = 13, val_b = 7, blank_lz = 0:
- next cycle BLANK with an = 1111;
- then an = 0111, seg = 79; an = 1011, seg = 30; an = 1101, seg = 40; an = 1110, seg = 78;
- frame_done pulses every 16 cycles.
REQ-031 Same load with blank_lz = 1 -> the digit 1 slot shows an = 1101, seg = 7F; all other digits are unchanged.
REQ-032 Mid-frame load of val_a = 9, val_b = 15:
- ready = 0 until the frame boundary;
- the old digits finish the current frame;
- the next frame shows 0, 9, 1, 5;
- ready = 1 one cycle after frame_done.
REQ-033 Second load while ready = 0 -> ignored; the first value is displayed.
REQ-034 Assert rst_n = 0 during digit 2 SHOW -> next cycle an = 1111, seg = 7F, ready = 1; the module stays in IDLE until the next load.
REQ-035 Sweep val_a = val_b = 0..15 -> tens digit = (v > 9), ones digit = v mod 10 for every value.
